dma_mem_responder: RTL

DMA_MEM_RESPONDER -- requirements
Module: dma_mem_responder

---
 rtl/dma_pkg.sv | 9 +
 rtl/dma_mem_array.sv | 24 ++
 rtl/dma_mem_responder.sv | 112 +++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: FSM state and latency-counter width shared by the DMA initiator and responder blocks
package dma_pkg;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, ACK} dma_state_e;
    // Counter value loaded at accept; the ack fires in the cycle the counter reads zero
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        return CNT_W'(lat - 1);
    endfunction
endpackage

// File: rtl/dma_mem_array.sv
// dma_mem_array: single-port synchronous RAM, read-during-write returns the old word
module dma_mem_array #(
    parameter int  DATA_W = 64,
    parameter int  DEPTH  = 1024,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    // Registered read of the pre-write word; no reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) mem_q[addr_i] <= wdata_i;
            rdata_q <= mem_q[addr_i];
        end
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/dma_mem_responder.sv
// dma_mem_responder: one-transaction-at-a-time memory responder with fixed read/write latency.
// Define DMA_MEM_RESP_RANGE_CHECK_EN to discard out-of-range accesses and raise sticky err
// instead of wrapping the word index modulo DEPTH.
module dma_mem_responder
    import dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_rd_req,
    input  logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_rd_ack,
    output logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_wr_req,
    input  logic [ADDR_W-1:0] mem_wr_addr,
    input  logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_ack,
    output logic              busy,
    output logic              err
);
    localparam int OFF = $clog2(DATA_W / 8);
    localparam int AW  = $clog2(DEPTH);

    dma_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d, ram_addr;
    logic [DATA_W-1:0] wdata_q, wdata_d, rd_hold_q, ram_rdata;
    logic              oor_q, oor_d, err_q, err_d;
    logic              acc_wr, acc_rd, req_oor, ram_en, ram_we;
    logic [ADDR_W-1:0] req_addr;

    // Write wins a same-cycle tie; the read stays pending until the FSM is idle again
    assign acc_wr   = state_q == IDLE && mem_wr_req;
    assign acc_rd   = state_q == IDLE && mem_rd_req && !mem_wr_req;
    assign req_addr = mem_wr_req ? mem_wr_addr : mem_rd_addr;
`ifdef DMA_MEM_RESP_RANGE_CHECK_EN
    assign req_oor  = (req_addr >> (OFF + AW)) != '0;
`else
    assign req_oor  = 1'b0;
`endif
    assign mem_rd_ack  = state_q == RD_WAIT && cnt_q == '0;
    assign mem_wr_ack  = state_q == WR_WAIT && cnt_q == '0;
    assign mem_rd_data = mem_rd_ack ? (oor_q ? '0 : ram_rdata) : rd_hold_q;
    assign busy        = state_q inside {RD_WAIT, WR_WAIT};
    assign err         = err_q;
    // Reads hit the RAM at the accept edge so every earlier acked write is visible;
    // writes commit on the edge that ends the write-ack cycle
    assign ram_we   = mem_wr_ack && !oor_q;
    assign ram_en   = acc_rd || ram_we;
    assign ram_addr = acc_rd ? AW'(mem_rd_addr >> OFF) : idx_q;

    dma_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    // Next state: accept in IDLE, count down in the wait states, then one ACK cycle that ignores requests
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        oor_d   = oor_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (acc_wr || acc_rd) begin
                state_d = acc_wr ? WR_WAIT : RD_WAIT;
                cnt_d   = acc_wr ? lat_load(WR_LAT) : lat_load(RD_LAT);
                idx_d   = AW'(req_addr >> OFF);
                wdata_d = mem_wr_data;
                oor_d   = req_oor;
            end
            RD_WAIT, WR_WAIT: if (cnt_q == '0) begin
                state_d = ACK;
                err_d   = err_q | oor_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            oor_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_hold_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
            err_q   <= err_d;
            if (mem_rd_ack) rd_hold_q <= mem_rd_data;
        end
    end
endmodule
